// File: rtl/axi4_addr_arbiter_if.sv
// Address-channel bundle between masters, decoder, slaves and the
// error responder for one AW or AR arbiter.
interface axi4_addr_arbiter_if #(
  parameter int NUM_MASTERS = 2,
  parameter int NUM_SLAVES  = 3,
  parameter int ADDR_WIDTH  = 32
);
  localparam int MID_W = $clog2(NUM_MASTERS);

  logic [NUM_MASTERS-1:0]            m_valid;
  logic [NUM_MASTERS*ADDR_WIDTH-1:0] m_addr;
  logic [NUM_MASTERS*3-1:0]          m_prot;
  logic [NUM_MASTERS-1:0]            m_ready;
  logic                              dec_valid;
  logic [ADDR_WIDTH-1:0]             dec_addr;
  logic [2:0]                        dec_prot;
  logic [MID_W-1:0]                  dec_master_id;
  logic [NUM_SLAVES-1:0]             dec_slave_select;
  logic                              dec_access_error;
  logic [NUM_SLAVES-1:0]             s_valid;
  logic [ADDR_WIDTH-1:0]             s_addr;
  logic [2:0]                        s_prot;
  logic [MID_W-1:0]                  s_master_id;
  logic [NUM_SLAVES-1:0]             s_ready;
  logic                              err_valid;
  logic [MID_W-1:0]                  err_master_id;
  logic                              err_ready;
  logic [7:0]                        decerr_count;

  modport slave (
    input  m_valid, m_addr, m_prot,
    input  dec_slave_select, dec_access_error,
    input  s_ready, err_ready,
    output m_ready, dec_valid, dec_addr,
    output dec_prot, dec_master_id,
    output s_valid, s_addr, s_prot, s_master_id,
    output err_valid, err_master_id, decerr_count
  );

  modport master (
    output m_valid, m_addr, m_prot,
    output dec_slave_select, dec_access_error,
    output s_ready, err_ready,
    input  m_ready, dec_valid, dec_addr,
    input  dec_prot, dec_master_id,
    input  s_valid, s_addr, s_prot, s_master_id,
    input  err_valid, err_master_id, decerr_count
  );
endinterface

// File: rtl/axi4_addr_arbiter.sv
// Round-robin address-channel arbiter: grant, decode, then issue to a
// slave or route to the default error responder.
module axi4_addr_arbiter #(
  parameter int NUM_MASTERS = 2,
  parameter int NUM_SLAVES  = 3,
  parameter int ADDR_WIDTH  = 32
) (
  input logic            aclk,
  input logic            aresetn,
  axi4_addr_arbiter_if.slave bus
);
  localparam int MID_W = $clog2(NUM_MASTERS);

  typedef enum logic [1:0] {
    IDLE, DECODE, ISSUE, ERROR
  } state_e;

  state_e                state_q, state_d;
  logic [MID_W-1:0]      rr_q, rr_d;
  logic [MID_W-1:0]      id_q, id_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [2:0]            prot_q, prot_d;
  logic [NUM_SLAVES-1:0] sel_q, sel_d;
  logic [NUM_SLAVES-1:0] sel_low;
  logic [7:0]            cnt_q, cnt_d;
  logic [MID_W-1:0]      win;
  logic                  found;
  int                    j;

  // Scan rr_q, rr_q+1, ... with explicit wrap for any master count
  always_comb begin
    win   = '0;
    found = 1'b0;
    j     = 0;
    for (int k = 0; k < NUM_MASTERS; k++) begin
      j = int'(rr_q) + k;
      if (j >= NUM_MASTERS) j = j - NUM_MASTERS;
      if (!found && bus.m_valid[j[MID_W-1:0]]) begin
        found = 1'b1;
        win   = j[MID_W-1:0];
      end
    end
  end

  // Lowest set bit breaks overlapping decoder regions
  assign sel_low = bus.dec_slave_select &
                   (~bus.dec_slave_select + NUM_SLAVES'(1));

  always_comb begin
    state_d       = state_q;
    rr_d          = rr_q;
    id_d          = id_q;
    addr_d        = addr_q;
    prot_d        = prot_q;
    sel_d         = sel_q;
    cnt_d         = cnt_q;
    bus.m_ready   = '0;
    bus.dec_valid = 1'b0;
    bus.s_valid   = '0;
    bus.err_valid = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (found && aresetn) begin
          bus.m_ready[win] = 1'b1;
          id_d    = win;
          addr_d  = bus.m_addr[int'(win)*ADDR_WIDTH +: ADDR_WIDTH];
          prot_d  = bus.m_prot[int'(win)*3 +: 3];
          rr_d    = (win == MID_W'(NUM_MASTERS-1)) ?
                    '0 : win + 1'b1;
          state_d = DECODE;
        end
      end
      DECODE: begin
        bus.dec_valid = 1'b1;
        sel_d = sel_low;
        if (bus.dec_access_error ||
            bus.dec_slave_select == '0)
          state_d = ERROR;
        else
          state_d = ISSUE;
      end
      ISSUE: begin
        bus.s_valid = sel_q;
        if (|(sel_q & bus.s_ready)) state_d = IDLE;
      end
      ERROR: begin
        bus.err_valid = 1'b1;
        if (bus.err_ready) begin
          state_d = IDLE;
          if (cnt_q != 8'hFF) cnt_d = cnt_q + 8'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state_q <= IDLE;
      rr_q    <= '0;
      id_q    <= '0;
      addr_q  <= '0;
      prot_q  <= '0;
      sel_q   <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      rr_q    <= rr_d;
      id_q    <= id_d;
      addr_q  <= addr_d;
      prot_q  <= prot_d;
      sel_q   <= sel_d;
      cnt_q   <= cnt_d;
    end
  end

  assign bus.dec_addr      = addr_q;
  assign bus.dec_prot      = prot_q;
  assign bus.dec_master_id = id_q;
  assign bus.s_addr        = addr_q;
  assign bus.s_prot        = prot_q;
  assign bus.s_master_id   = id_q;
  assign bus.err_master_id = id_q;
  assign bus.decerr_count  = cnt_q;
endmodule

// File: tb/tb_axi4_addr_arbiter.sv
// Directed bench for axi4_addr_arbiter with a small address decoder
// model: region 0x0/0x1/0x2 map to slaves 0/1/2, all else unmapped.
module tb_axi4_addr_arbiter;
  logic aclk = 1'b0;
  logic aresetn = 1'b0;
  logic force_err = 1'b0;
  int total = 0;
  int bad = 0;

  always #5 aclk = ~aclk;

  axi4_addr_arbiter_if #(
    .NUM_MASTERS(2), .NUM_SLAVES(3), .ADDR_WIDTH(32)
  ) bus ();

  axi4_addr_arbiter #(
    .NUM_MASTERS(2), .NUM_SLAVES(3), .ADDR_WIDTH(32)
  ) dut (
    .aclk(aclk),
    .aresetn(aresetn),
    .bus(bus.slave)
  );

  always_comb begin
    bus.dec_slave_select = 3'b000;
    unique case (bus.dec_addr[31:28])
      4'h0: bus.dec_slave_select = 3'b001;
      4'h1: bus.dec_slave_select = 3'b010;
      4'h2: bus.dec_slave_select = 3'b100;
      default: bus.dec_slave_select = 3'b000;
    endcase
    bus.dec_access_error = force_err;
  end

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge aclk);
    #2;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic do_reset();
    aresetn = 1'b0;
    step();
    step();
    aresetn = 1'b1;
    settle();
  endtask

  initial begin
    bus.m_valid   = '0;
    bus.m_addr    = '0;
    bus.m_prot    = '0;
    bus.s_ready   = '0;
    bus.err_ready = 1'b0;

    // Reset state
    step();
    step();
    chk("rst_mready", 32'(bus.m_ready), 32'd0);
    chk("rst_decv", 32'(bus.dec_valid), 32'd0);
    chk("rst_sv", 32'(bus.s_valid), 32'd0);
    chk("rst_errv", 32'(bus.err_valid), 32'd0);
    chk("rst_daddr", bus.dec_addr, 32'd0);
    chk("rst_cnt", 32'(bus.decerr_count), 32'd0);
    aresetn = 1'b1;
    settle();

    // T1 single request to slave 2
    bus.m_addr[31:0] = 32'h2000_0010;
    bus.m_prot[2:0]  = 3'b101;
    bus.m_valid = 2'b01;
    settle();
    chk("t1_mready_c0", 32'(bus.m_ready), 32'd1);
    chk("t1_decv_c0", 32'(bus.dec_valid), 32'd0);
    step();
    bus.m_valid = 2'b00;
    settle();
    chk("t1_decv_c1", 32'(bus.dec_valid), 32'd1);
    chk("t1_mready_c1", 32'(bus.m_ready), 32'd0);
    chk("t1_daddr", bus.dec_addr, 32'h2000_0010);
    chk("t1_dprot", 32'(bus.dec_prot), 32'd5);
    step();
    chk("t1_sv_c2", 32'(bus.s_valid), 32'b100);
    chk("t1_saddr", bus.s_addr, 32'h2000_0010);
    chk("t1_smid", 32'(bus.s_master_id), 32'd0);
    chk("t1_decv_c2", 32'(bus.dec_valid), 32'd0);
    bus.s_ready = 3'b111;
    step();
    chk("t1_sv_done", 32'(bus.s_valid), 32'd0);

    // T2 both masters continuously valid, grants alternate from 0
    do_reset();
    bus.m_addr = {32'h1000_0200, 32'h0000_0100};
    bus.m_valid = 2'b11;
    bus.s_ready = 3'b111;
    for (int g = 0; g < 4; g++) begin
      settle();
      chk("t2_mready", 32'(bus.m_ready), (g % 2 == 0) ? 32'd1 : 32'd2);
      step();
      chk("t2_decmid", 32'(bus.dec_master_id), 32'(g % 2));
      chk("t2_mready_dec", 32'(bus.m_ready), 32'd0);
      step();
      chk("t2_sv", 32'(bus.s_valid),
          (g % 2 == 0) ? 32'b001 : 32'b010);
      chk("t2_saddr", bus.s_addr,
          (g % 2 == 0) ? 32'h0000_0100 : 32'h1000_0200);
      step();
    end
    bus.m_valid = 2'b00;
    bus.s_ready = 3'b000;
    settle();

    // T3 unmapped address from master 1 goes to the error responder
    bus.m_addr[63:32] = 32'hF000_0000;
    bus.m_valid = 2'b10;
    settle();
    chk("t3_mready", 32'(bus.m_ready), 32'd2);
    step();
    bus.m_valid = 2'b00;
    step();
    chk("t3_errv", 32'(bus.err_valid), 32'd1);
    chk("t3_errmid", 32'(bus.err_master_id), 32'd1);
    chk("t3_sv", 32'(bus.s_valid), 32'd0);
    chk("t3_cnt0", 32'(bus.decerr_count), 32'd0);
    step();
    chk("t3_errv_hold", 32'(bus.err_valid), 32'd1);
    bus.err_ready = 1'b1;
    step();
    bus.err_ready = 1'b0;
    settle();
    chk("t3_errv_done", 32'(bus.err_valid), 32'd0);
    chk("t3_cnt1", 32'(bus.decerr_count), 32'd1);

    // T4 slave stalls for 5 cycles in ISSUE
    bus.m_addr[31:0] = 32'h1000_0040;
    bus.m_valid = 2'b01;
    step();
    bus.m_valid = 2'b00;
    step();
    bus.m_valid = 2'b11;
    for (int c = 0; c < 5; c++) begin
      settle();
      chk("t4_sv", 32'(bus.s_valid), 32'b010);
      chk("t4_saddr", bus.s_addr, 32'h1000_0040);
      chk("t4_mready", 32'(bus.m_ready), 32'd0);
      step();
    end
    bus.s_ready = 3'b010;
    settle();
    chk("t4_sv_last", 32'(bus.s_valid), 32'b010);
    bus.m_valid = 2'b00;
    step();
    chk("t4_sv_done", 32'(bus.s_valid), 32'd0);
    bus.s_ready = 3'b000;

    // T5 forced access error on a mapped address, counter saturates
    force_err = 1'b1;
    bus.err_ready = 1'b1;
    bus.m_addr[31:0] = 32'h0000_0000;
    bus.m_valid = 2'b01;
    for (int r = 0; r < 300; r++) begin
      step();
      step();
      if (r == 0) begin
        chk("t5_errv", 32'(bus.err_valid), 32'd1);
        chk("t5_sv", 32'(bus.s_valid), 32'd0);
      end
      step();
      if (r == 9) chk("t5_cnt11", 32'(bus.decerr_count), 32'd11);
      if (r == 253) chk("t5_cnt255", 32'(bus.decerr_count), 32'd255);
    end
    chk("t5_sat", 32'(bus.decerr_count), 32'd255);
    bus.m_valid = 2'b00;
    force_err = 1'b0;
    bus.err_ready = 1'b0;
    settle();

    // T6 reset in the middle of ISSUE
    bus.m_addr[31:0] = 32'h2000_0080;
    bus.m_valid = 2'b01;
    step();
    bus.m_valid = 2'b00;
    step();
    chk("t6_sv_pre", 32'(bus.s_valid), 32'b100);
    bus.m_valid = 2'b11;
    aresetn = 1'b0;
    settle();
    chk("t6_sv_rst", 32'(bus.s_valid), 32'd0);
    chk("t6_mready_rst", 32'(bus.m_ready), 32'd0);
    chk("t6_errv_rst", 32'(bus.err_valid), 32'd0);
    chk("t6_daddr_rst", bus.dec_addr, 32'd0);
    chk("t6_cnt_rst", 32'(bus.decerr_count), 32'd0);
    step();
    aresetn = 1'b1;
    settle();
    chk("t6_mready_rel", 32'(bus.m_ready), 32'd1);
    step();
    chk("t6_decmid", 32'(bus.dec_master_id), 32'd0);
    chk("t6_daddr", bus.dec_addr, 32'h2000_0080);
    bus.m_valid = 2'b00;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
